// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO drain controller and its skid buffer.
package fifo_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PKT_LEN = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    STALL  = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer with push/pop/clear; entry 0 is always the head.
// With FIFO_DRAIN_PARITY_EN defined, each entry also stores the even parity of its data.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
`ifdef FIFO_DRAIN_PARITY_EN
  output logic              dout_par,
`endif
  output logic [1:0]        occ,
  output logic [1:0]        occ_nxt
);

`ifdef FIFO_DRAIN_PARITY_EN
  localparam int EW = DATA_W + 1;
`else
  localparam int EW = DATA_W;
`endif

  logic [EW-1:0] din_ent;
  logic [EW-1:0] ent_q [2];
  logic [EW-1:0] ent_d [2];
  logic [1:0]    occ_q;
  logic [1:0]    occ_d;

`ifdef FIFO_DRAIN_PARITY_EN
  assign din_ent  = {^din, din};
  assign dout_par = ent_q[0][DATA_W];
`else
  assign din_ent  = din;
`endif

  assign dout    = ent_q[0][DATA_W-1:0];
  assign occ     = occ_q;
  assign occ_nxt = occ_d;

  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    occ_d    = occ_q;
    if (clr) begin
      occ_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          ent_d[occ_q[0]] = din_ent;
          occ_d           = occ_q + 2'd1;
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          occ_d    = occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (occ_q[1]) begin
            ent_d[0] = ent_q[1];
            ent_d[1] = din_ent;
          end else begin
            ent_d[0] = din_ent;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ent
    always_ff @(posedge clk) begin
      if (!rst) ent_q[gi] <= '0;
      else      ent_q[gi] <= ent_d[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) occ_q <= 2'd0;
    else      occ_q <= occ_d;
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a one-cycle-latency FIFO into a ready/valid packet stream with out_last framing.
// Optional out_parity port is built when FIFO_DRAIN_PARITY_EN is defined.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PKT_LEN = DEF_PKT_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_out,
  output logic              r_en,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
`ifdef FIFO_DRAIN_PARITY_EN
  output logic              out_parity,
`endif
  output logic              out_last
);

  localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [1:0]    occ, occ_nxt;
  logic          push, pop, rd_ok;

  assign out_valid = (occ != 2'd0);
  assign out_last  = out_valid && (beat_q == LAST_BEAT);
  assign pop       = out_valid && out_ready;
  assign push      = pend_q && !flush;

  // A read is safe when skid slots plus the in-flight word, net of this cycle's pop, stay under two.
  always_comb begin
    rd_ok = 1'b0;
    unique case (state_q)
      IDLE:    rd_ok = 1'b1;
      STREAM:  rd_ok = !(occ[0] && pend_q) || pop;
      STALL:   rd_ok = pop;
      default: rd_ok = 1'b0;
    endcase
  end

  assign r_en = rst && !buf_empty && !flush && rd_ok;

  always_comb begin
    pend_d = r_en;
    beat_d = beat_q;
    if (flush)
      beat_d = '0;
    else if (pop)
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    if (occ_nxt == 2'd2)
      state_d = STALL;
    else if (occ_nxt == 2'd0 && !pend_d)
      state_d = IDLE;
    else
      state_d = STREAM;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      beat_q  <= beat_d;
    end
  end

  fifo_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push    (push),
    .pop     (pop),
    .din     (buf_out),
    .dout    (out_data),
`ifdef FIFO_DRAIN_PARITY_EN
    .dout_par(out_parity),
`endif
    .occ     (occ),
    .occ_nxt (occ_nxt)
  );

endmodule
